virq_injector: RTL and testbench
================================

// Module: virq_injector
// PURPOSE
//  Delivers virtual interrupts from the hypervisor to the guest. This is the reverse path of the trap logic,
//  which pulls system IRQs and I/O violations into the hypervisor via NMI.
//  The hypervisor queues 8-bit IM2 vectors. While the guest runs (trap reset, virtualization on), the block
//  holds the guest INT line and answers the interrupt-acknowledge cycle with the queued vector.
// PARAMETERS
//  DEPTH   4  vector FIFO entries (power of two, >=2)
//  ADDR_W  2  log2(DEPTH); count width is ADDR_W+1
// PORTS
//  clk              in   1         Z80 system clock; all state changes on posedge
//  rst              in   1         reset, asynchronous, active-high
//  wr_en            in   1         hypervisor write strobe (one clk per write)
//  wr_data          in   8         vector to enqueue
//  clr              in   1         synchronous flush of FIFO and overflow flag
//  trap_state       in   1         1 = hypervisor owns CPU (from trap logic)
//  virtual_enabled  in   1         virtualization active
//  m1_n             in   1         Z80 /M1
//  iorq_n           in   1         Z80 /IORQ
//  int_n            out  1         guest interrupt request, active-low, registered
//  vec_out          out  8         vector driven during acknowledge, registered
//  vec_oe           out  1         data-bus output enable for vec_out, registered
//  count            out  ADDR_W+1  FIFO occupancy 0..DEPTH
//  empty            out  1         count==0
//  full             out  1         count==DEPTH
//  overflow         out  1         sticky: a write was dropped while full
// BEHAVIOUR
//  Reset values: int_n=1, vec_oe=0, vec_out=0, count=0, empty=1, full=0, overflow=0, state=IDLE, pointers=0.
//  Definitions:
//   - ack = !m1_n && !iorq_n, sampled at posedge clk
//   - run = virtual_enabled && !trap_state
//  FIFO:
//   - wr_en && !full enqueues wr_data at the tail; count updates the next edge.
//   - Pop only on ASSERT->ACK entry; head vector is latched into vec_out at that edge.
//   - wr_en while full and no pop that cycle: data dropped, overflow<=1.
//   - Write and pop in the same cycle: both occur, count unchanged; this is allowed even when full.
//   - Pointers wrap modulo DEPTH.
//   - clr: count<=0, pointers<=0, overflow<=0. clr takes priority over a same-cycle wr_en and pop.
//  FSM (int_n and vec_oe are decoded into registers from the next state):
//   - IDLE: int_n=1. Go to ASSERT when run && !empty && !clr.
//   - ASSERT: int_n=0.
//     - If ack: go to ACK, pop, vec_out<=head, vec_oe<=1.
//     - Else if !run || empty: go to IDLE, int_n<=1; the vector stays queued.
//   - ACK: int_n=1, vec_oe=1. Stay while ack. When ack is low, go to REL with vec_oe<=0.
//     Changes to trap_state, virtual_enabled or clr do not abort ACK; vec_out stays stable.
//   - REL: int_n=1, vec_oe=0 for exactly one clk (guaranteed INT gap), then IDLE.
//  Latency:
//   - wr_en at edge N into an empty FIFO with run=1: count=1 after N, int_n=0 after N+1.
//   - ack first sampled at edge K: vec_oe=1 after K.
//   - ack released, sampled at edge J: vec_oe=0 after J, REL; IDLE after J+1.
//     If entries remain, int_n=0 again after J+2.
//  Other cases:
//   - ack seen in IDLE or REL is ignored; vec_oe stays 0.
//   - trap_state rising during ASSERT: int_n goes high next edge.
//   - rst at any point forces the reset values immediately, including mid-ACK (vec_oe drops asynchronously).
// TESTING
//  1. Reset, run=1. Write 0x10 at edge 0. Required: count=1 after edge 0, int_n=0 after edge 1,
//     empty=0; then drive ack for 3 clks -> vec_out=0x10, vec_oe=1 for 3 clks; count=0;
//     after ack release int_n=1.
//  2. Write 0x20,0x22,0x24 back-to-back; complete 3 acks -> vectors in order 0x20,0x22,0x24;
//     int_n high >=1 clk between each ack; empty=1 at end.
//  3. Fill DEPTH=4 (0xA0..0xA3), write 0xFF -> full=1, overflow=1, count=4; acks return 0xA0..0xA3,
//     0xFF is never seen; clr -> overflow=0.
//  4. Queue 0x40, int_n=0, raise trap_state -> int_n=1 next clk, count=1; drive ack -> vec_oe stays 0;
//     drop trap_state -> int_n=0, ack returns 0x40.
//  5. Mid-ACK (vector 0x55, 2 more queued), pulse clr and raise trap_state -> vec_out=0x55 held
//     until ack ends; count=0 after clr; no new int_n assertion.
//  6. Assert rst during ACK -> int_n=1, vec_oe=0, count=0 immediately (before next clk edge);
//     full with simultaneous write+ack entry -> count stays 4, overflow=0.

Source files
------------

// File: rtl/virq_injector.sv
// virq_injector
//   Delivers virtual interrupts from the hypervisor to the guest. This is the
//   reverse of the trap path, which pulls system IRQs into the hypervisor via NMI.
//   The hypervisor queues 8-bit IM2 vectors. While the guest runs (trap released
//   and virtualization on), this block pulls the guest INT line low. It answers
//   the Z80 interrupt-acknowledge cycle by driving the queued vector.
//
// Ports
//   clk, rst         system clock and asynchronous active-high reset
//   wr_en, wr_data   hypervisor enqueue strobe and vector
//   clr              synchronous flush of the FIFO and the overflow flag
//   trap_state       1 while the hypervisor owns the CPU
//   virtual_enabled  virtualization active
//   m1_n, iorq_n     Z80 bus strobes; both low means interrupt acknowledge
//   int_n            guest interrupt request, active-low, registered
//   vec_out, vec_oe  acknowledge vector and its bus enable, registered
//   count            FIFO occupancy 0..DEPTH
//   empty, full      occupancy flags
//   overflow         sticky flag: a write was dropped while the FIFO was full
module virq_injector #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr,
  input  logic              trap_state,
  input  logic              virtual_enabled,
  input  logic              m1_n,
  input  logic              iorq_n,
  output logic              int_n,
  output logic [7:0]        vec_out,
  output logic              vec_oe,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ASSERT, ACK, REL} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  state_t            r_state;
  logic              r_intN;
  logic              r_vecOe;
  logic [7:0]        r_vecOut;

  logic       w_ack;
  logic       w_run;
  logic       w_pop;
  logic       w_push;
  logic [7:0] w_head;

  assign w_ack  = !m1_n && !iorq_n;
  assign w_run  = virtual_enabled && !trap_state;
  assign w_head = r_mem[r_rdPtr];

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign int_n    = r_intN;
  assign vec_oe   = r_vecOe;
  assign vec_out  = r_vecOut;

  // The head leaves the FIFO only when the acknowledge cycle is accepted.
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  // A flush overrides both the pop and the push.
  assign w_pop  = (r_state == ASSERT) && w_ack && !empty && !clr;
  assign w_push = wr_en && (!full || w_pop) && !clr;

  // Vector storage needs no reset; occupancy is tracked by the count and pointers.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + ADDR_W'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + ADDR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (ADDR_W+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (ADDR_W+1)'(1);
      if (wr_en && full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  // Interrupt handshake FSM. The outputs are registered from the state being entered.
  // Once the acknowledge cycle is under way (ACK), only the bus strobes can end it.
  // This keeps the vector stable for the whole cycle.
  // REL holds INT high for one clock, so the guest always sees a gap between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_intN   <= 1'b1;
      r_vecOe  <= 1'b0;
      r_vecOut <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_run && !empty && !clr) begin
            r_state <= ASSERT;
            r_intN  <= 1'b0;
          end
        end
        ASSERT: begin
          if (w_ack && !empty) begin
            r_state  <= ACK;
            r_intN   <= 1'b1;
            r_vecOe  <= 1'b1;
            r_vecOut <= w_head;
          end else if (!w_run || empty) begin
            r_state <= IDLE;
            r_intN  <= 1'b1;
          end
        end
        ACK: begin
          if (!w_ack) begin
            r_state <= REL;
            r_vecOe <= 1'b0;
          end
        end
        REL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_intN  <= 1'b1;
          r_vecOe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_virq_injector.sv
// tb_virq_injector
//   Directed bench for virq_injector. Accepted vectors are pushed to a scoreboard
//   queue as they are written. They are popped and compared when the DUT enters
//   an acknowledge cycle.
module tb_virq_injector;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr;
  logic       trap_state;
  logic       virtual_enabled;
  logic       m1_n;
  logic       iorq_n;
  logic       int_n;
  logic [7:0] vec_out;
  logic       vec_oe;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  virq_injector #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .trap_state(trap_state), .virtual_enabled(virtual_enabled),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n), .vec_out(vec_out),
    .vec_oe(vec_oe), .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one vector; the model accepts it only if the FIFO has room
  task automatic applyStimulus(input logic [7:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
    if (sb.size() < 4)
      sb.push_back(v);
  endtask

  // Bounded wait for the guest interrupt request
  task automatic waitIntLow(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (int_n === 1'b0) break;
      tick();
    end
    checkOutput(tag, {7'b0, int_n}, 8'h00);
  endtask

  // Acknowledge cycle held for n clocks, then released, then the INT gap
  task automatic doAck(input int n, input string tag);
    logic [7:0] expVec;
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_sb_underflow: observed=%h expected=none", tag, vec_out);
      expVec = 8'h00;
    end else begin
      expVec = sb.pop_front();
    end
    checkOutput({tag, "_vec"}, vec_out, expVec);
    checkOutput({tag, "_oe"}, {7'b0, vec_oe}, 8'h01);
    for (int i = 1; i < n; i++) begin
      tick();
      checkOutput({tag, "_oe_hold"}, {7'b0, vec_oe}, 8'h01);
      checkOutput({tag, "_vec_hold"}, vec_out, expVec);
    end
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    checkOutput({tag, "_rel_oe"}, {7'b0, vec_oe}, 8'h00);
    checkOutput({tag, "_rel_int"}, {7'b0, int_n}, 8'h01);
    tick();
    checkOutput({tag, "_gap_int"}, {7'b0, int_n}, 8'h01);
  endtask

  initial begin
    rst             = 1'b1;
    wr_en           = 1'b0;
    wr_data         = 8'h00;
    clr             = 1'b0;
    trap_state      = 1'b0;
    virtual_enabled = 1'b1;
    m1_n            = 1'b1;
    iorq_n          = 1'b1;
    #12;
    checkOutput("rst_int", {7'b0, int_n}, 8'h01);
    checkOutput("rst_oe", {7'b0, vec_oe}, 8'h00);
    checkOutput("rst_vec", vec_out, 8'h00);
    checkOutput("rst_count", {5'b0, count}, 8'h00);
    checkOutput("rst_empty", {7'b0, empty}, 8'h01);
    checkOutput("rst_full", {7'b0, full}, 8'h00);
    checkOutput("rst_ovf", {7'b0, overflow}, 8'h00);
    rst = 1'b0;
    tick();

    // Single vector: latency and a 3-clock acknowledge
    applyStimulus(8'h10);
    checkOutput("t1_count", {5'b0, count}, 8'h01);
    checkOutput("t1_empty", {7'b0, empty}, 8'h00);
    checkOutput("t1_int_early", {7'b0, int_n}, 8'h01);
    tick();
    checkOutput("t1_int_low", {7'b0, int_n}, 8'h00);
    doAck(3, "t1");
    checkOutput("t1_count_end", {5'b0, count}, 8'h00);

    // Three back-to-back vectors delivered in order
    applyStimulus(8'h20);
    applyStimulus(8'h22);
    applyStimulus(8'h24);
    checkOutput("t2_count", {5'b0, count}, 8'h03);
    for (int k = 0; k < 3; k++) begin
      waitIntLow("t2_wait");
      doAck(1, "t2");
    end
    checkOutput("t2_empty", {7'b0, empty}, 8'h01);

    // Fill, overflow, drain, flush
    applyStimulus(8'hA0);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hFF);
    checkOutput("t3_full", {7'b0, full}, 8'h01);
    checkOutput("t3_ovf", {7'b0, overflow}, 8'h01);
    checkOutput("t3_count", {5'b0, count}, 8'h04);
    for (int k = 0; k < 4; k++) begin
      waitIntLow("t3_wait");
      doAck(1, "t3");
    end
    checkOutput("t3_empty", {7'b0, empty}, 8'h01);
    checkOutput("t3_ovf_sticky", {7'b0, overflow}, 8'h01);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("t3_ovf_clr", {7'b0, overflow}, 8'h00);

    // Trap during a pending request, ack ignored while idle
    applyStimulus(8'h40);
    waitIntLow("t4_wait");
    trap_state = 1'b1;
    tick();
    checkOutput("t4_int_drop", {7'b0, int_n}, 8'h01);
    checkOutput("t4_count", {5'b0, count}, 8'h01);
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
    tick();
    checkOutput("t4_oe_ignored", {7'b0, vec_oe}, 8'h00);
    checkOutput("t4_int_ignored", {7'b0, int_n}, 8'h01);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    trap_state = 1'b0;
    tick();
    waitIntLow("t4_wait2");
    doAck(1, "t4");

    // Flush and trap during an acknowledge do not disturb it
    applyStimulus(8'h55);
    applyStimulus(8'h56);
    applyStimulus(8'h57);
    waitIntLow("t5_wait");
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
    checkOutput("t5_vec", vec_out, sb.pop_front());
    clr        = 1'b1;
    trap_state = 1'b1;
    tick();
    clr = 1'b0;
    sb.delete();
    checkOutput("t5_count_clr", {5'b0, count}, 8'h00);
    checkOutput("t5_oe_hold", {7'b0, vec_oe}, 8'h01);
    checkOutput("t5_vec_hold", vec_out, 8'h55);
    tick();
    checkOutput("t5_vec_hold2", vec_out, 8'h55);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    checkOutput("t5_oe_rel", {7'b0, vec_oe}, 8'h00);
    trap_state = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t5_no_int", {7'b0, int_n}, 8'h01);
    end

    // Asynchronous reset in the middle of an acknowledge
    applyStimulus(8'h60);
    waitIntLow("t6_wait");
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
    checkOutput("t6_oe_pre", {7'b0, vec_oe}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_int", {7'b0, int_n}, 8'h01);
    checkOutput("t6_rst_oe", {7'b0, vec_oe}, 8'h00);
    checkOutput("t6_rst_count", {5'b0, count}, 8'h00);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    sb.delete();
    #1;
    rst = 1'b0;
    tick();

    // Full FIFO with a write in the same cycle the acknowledge is accepted
    applyStimulus(8'h70);
    applyStimulus(8'h71);
    applyStimulus(8'h72);
    applyStimulus(8'h73);
    checkOutput("t6_int_full", {7'b0, int_n}, 8'h00);
    wr_en   = 1'b1;
    wr_data = 8'h74;
    m1_n    = 1'b0;
    iorq_n  = 1'b0;
    tick();
    wr_en = 1'b0;
    checkOutput("t6_vec", vec_out, sb.pop_front());
    sb.push_back(8'h74);
    checkOutput("t6_count", {5'b0, count}, 8'h04);
    checkOutput("t6_full", {7'b0, full}, 8'h01);
    checkOutput("t6_ovf", {7'b0, overflow}, 8'h00);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    checkOutput("t6_oe_rel", {7'b0, vec_oe}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      waitIntLow("t6_wait2");
      doAck(1, "t6d");
    end
    checkOutput("t6_empty", {7'b0, empty}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
